mips_hazard_unit: RTL and testbench

MIPS_HAZARD_UNIT -- requirements
Module: mips_hazard_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/hazard_sb_entry_pipe.sv | 29 ++
 rtl/mips_hazard_unit.sv | 93 +++++++++
 tb/tb_mips_hazard_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS hazard unit: forwarding-select values and
// post-decode stage indices.
package mips_pkg;

  localparam int unsigned FWD_W   = 3;
  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  // Forwarding source: register file, or stage k reported as k+1.
  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 3'd0,
    FWD_EX  = 3'd1,
    FWD_MEM = 3'd2,
    FWD_WB  = 3'd3,
    FWD_S3  = 3'd4,
    FWD_S4  = 3'd5,
    FWD_S5  = 3'd6
  } fwd_sel_e;

  function automatic logic [FWD_W-1:0] fwd_of_stage(input int k);
    return FWD_W'(k + 1);
  endfunction

endpackage

// File: rtl/hazard_sb_entry_pipe.sv
// Shift register of in-flight destination entries {valid, dst, is_load};
// entry 0 is EX, older entries move one stage per clock and fall off the end.
module hazard_sb_entry_pipe #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned REG_AW = 5
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          load_valid,
  input  logic [REG_AW-1:0]             load_dst,
  input  logic                          load_is_load,
  output logic [NSTAGE-1:0]             ent_valid,
  output logic [NSTAGE-1:0][REG_AW-1:0] ent_dst,
  output logic [NSTAGE-1:0]             ent_is_load
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid   <= '0;
      ent_dst     <= '0;
      ent_is_load <= '0;
    end else begin
      ent_valid   <= {ent_valid[NSTAGE-2:0], load_valid};
      ent_dst     <= {ent_dst[NSTAGE-2:0], load_dst};
      ent_is_load <= {ent_is_load[NSTAGE-2:0], load_is_load};
    end
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Decode-stage hazard unit: youngest-producer forwarding selects, load-use
// stall generation, flush handling and saturating stall/flush statistics.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [FWD_W-1:0]  fwd_rs,
  output logic [FWD_W-1:0]  fwd_rt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NSTAGE-1:0]             ent_valid;
  logic [NSTAGE-1:0][REG_AW-1:0] ent_dst;
  logic [NSTAGE-1:0]             ent_is_load;
  logic [NSTAGE-1:0]             match_rs;
  logic [NSTAGE-1:0]             match_rt;
  logic                          hazard;
  logic                          accept;
  logic                          load_valid;
  logic                          load_is_load;
  logic                          stall_evt;

  hazard_sb_entry_pipe #(
    .NSTAGE (NSTAGE),
    .REG_AW (REG_AW)
  ) u_pipe (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_valid   (load_valid),
    .load_dst     (id_rd),
    .load_is_load (load_is_load),
    .ent_valid    (ent_valid),
    .ent_dst      (ent_dst),
    .ent_is_load  (ent_is_load)
  );

  // Per-stage source matches; $0 never matches since it is never written.
  always_comb begin
    match_rs = '0;
    match_rt = '0;
    for (int k = 0; k < int'(NSTAGE); k++) begin
      match_rs[k] = id_use_rs && (id_rs != '0) && ent_valid[k] && (ent_dst[k] == id_rs);
      match_rt[k] = id_use_rt && (id_rt != '0) && ent_valid[k] && (ent_dst[k] == id_rt);
    end
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_rs = FWD_RF;
    fwd_rt = FWD_RF;
    for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
      if (match_rs[k]) fwd_rs = fwd_of_stage(k);
      if (match_rt[k]) fwd_rt = fwd_of_stage(k);
    end
  end

  // Load data only exists at MEM output, so an EX-stage load consumer waits one cycle.
  assign hazard       = id_valid && ent_is_load[STG_EX] && (match_rs[STG_EX] || match_rt[STG_EX]);
  assign id_ready     = !hazard || flush;
  assign accept       = id_valid && id_ready && !flush;
  assign load_valid   = accept && id_wr_en && (id_rd != '0);
  assign load_is_load = load_valid && id_is_load;
  assign stall_evt    = hazard && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != CNT_MAX))     flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit: two instances (NSTAGE=3/CNT_W=16 and
// NSTAGE=5/CNT_W=4) share stimulus and are checked against a producer-history model.
module tb_mips_hazard_unit;

  logic       clock;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;

  logic        ready_a, ready_b;
  logic [2:0]  fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  mips_hazard_unit #(.REG_AW(5), .NSTAGE(3), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_ready(ready_a),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
    .fwd_rs(fwd_rs_a), .fwd_rt(fwd_rt_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  mips_hazard_unit #(.REG_AW(5), .NSTAGE(5), .CNT_W(4)) dut5 (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .id_ready(ready_b),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
    .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Producer history: hist[0] was issued last cycle, hist[k] k+1 cycles ago.
  typedef struct { bit v; int dst; bit ld; } prod_t;
  prod_t hist[5];
  int m_stall_a, m_flush_a, m_stall_b, m_flush_b;
  bit m_rdy;
  int n_assert, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 5; k++) hist[k] = '{0, 0, 0};
    m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
  endtask

  function automatic int m_fwd(input int src, input bit use_s, input int n);
    if (!use_s || src == 0) return 0;
    for (int k = 0; k < n; k++)
      if (hist[k].v && hist[k].dst == src) return k + 1;
    return 0;
  endfunction

  function automatic bit m_hazard();
    return id_valid && hist[0].v && hist[0].ld &&
           (m_fwd(int'(id_rs), id_use_rs, 1) == 1 || m_fwd(int'(id_rt), id_use_rt, 1) == 1);
  endfunction

  // Apply inputs, then compare every output of both instances with the model.
  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int rd, input bit ld, input bit fl);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wr_en = wr; id_rd = 5'(rd); id_is_load = ld; flush = fl;
    #1;
    m_rdy = !m_hazard() || fl;
    check("ready_a", 32'(ready_a), 32'(m_rdy));
    check("ready_b", 32'(ready_b), 32'(m_rdy));
    check("fwd_rs_a", 32'(fwd_rs_a), 32'(m_fwd(rs, urs, 3)));
    check("fwd_rt_a", 32'(fwd_rt_a), 32'(m_fwd(rt, urt, 3)));
    check("fwd_rs_b", 32'(fwd_rs_b), 32'(m_fwd(rs, urs, 5)));
    check("fwd_rt_b", 32'(fwd_rt_b), 32'(m_fwd(rt, urt, 5)));
    check("stall_a", 32'(stall_a), 32'(m_stall_a));
    check("flush_a", 32'(flush_a), 32'(m_flush_a));
    check("stall_b", 32'(stall_b), 32'(m_stall_b));
    check("flush_b", 32'(flush_b), 32'(m_flush_b));
  endtask

  task automatic tick();
    bit hz, acc;
    @(posedge clock);
    if (reset_n) begin
      hz  = m_hazard();
      acc = id_valid && (!hz || flush) && !flush;
      if (hz && !flush) begin
        if (m_stall_a < 65535) m_stall_a++;
        if (m_stall_b < 15) m_stall_b++;
      end
      if (flush) begin
        if (m_flush_a < 65535) m_flush_a++;
        if (m_flush_b < 15) m_flush_b++;
      end
      for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
      if (acc && id_wr_en && id_rd != 0) hist[0] = '{1, int'(id_rd), id_is_load};
      else hist[0] = '{0, 0, 0};
    end
    @(negedge clock);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    m_reset();
    reset_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wr_en = 0; id_rd = 0; id_is_load = 0; flush = 0;

    // Reset state, including with a would-be consumer on the inputs.
    #3;
    drive(1, 2, 2, 1, 1, 1, 2, 1, 0);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_fwd_rs", 32'(fwd_rs_a), 32'd0);
    check("rst_stall", 32'(stall_a), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // lw $2 ; add $3,$1,$2 -> one stall, then forward from MEM.
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0); tick();
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
    check("lu_ready", 32'(ready_a), 32'd0);
    tick();
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0);
    check("lu_stall_cnt", 32'(stall_a), 32'd1);
    check("lu_fwd_rt_mem", 32'(fwd_rt_a), 32'd2);
    check("lu_ready2", 32'(ready_a), 32'd1);
    tick();
    nops(5);

    // add $3,$1,$2 ; sub $1,$3,$2 -> no stall, EX forward on rs.
    drive(1, 1, 2, 1, 1, 1, 3, 0, 0); tick();
    drive(1, 3, 2, 1, 1, 1, 1, 0, 0);
    check("alu_fwd_rs_ex", 32'(fwd_rs_a), 32'd1);
    check("alu_fwd_rt_rf", 32'(fwd_rt_a), 32'd0);
    check("alu_ready", 32'(ready_a), 32'd1);
    tick();
    nops(5);

    // Two writers of $3 in flight: youngest wins; $0 never forwards.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0); tick();
    drive(1, 3, 3, 1, 1, 0, 0, 0, 0);
    check("young_fwd_rs", 32'(fwd_rs_a), 32'd1);
    tick();
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check("zero_fwd_rs", 32'(fwd_rs_a), 32'd0);
    check("zero_ready", 32'(ready_a), 32'd1);
    tick();
    nops(5);

    // Load-use with flush in the same cycle: flush wins, bubble in EX.
    drive(1, 0, 0, 0, 0, 1, 4, 1, 0); tick();
    drive(1, 4, 0, 1, 0, 1, 5, 0, 1);
    check("fl_ready", 32'(ready_a), 32'd1);
    tick();
    drive(1, 4, 0, 1, 0, 0, 0, 0, 0);
    check("fl_flush_cnt", 32'(flush_a), 32'd1);
    check("fl_stall_cnt", 32'(stall_a), 32'd1);
    check("fl_fwd_rs_mem", 32'(fwd_rs_a), 32'd2);
    tick();
    nops(5);

    // Deep pipe: producer with 4 / 5 instructions between it and the consumer.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); tick();
    nops(4);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    check("deep_fwd_b5", 32'(fwd_rs_b), 32'd5);
    check("deep_fwd_a0", 32'(fwd_rs_a), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0); tick();
    nops(5);
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    check("deep_gone_b", 32'(fwd_rs_b), 32'd0);
    tick();

    // 20 load-use stalls saturate the 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 1, 6, 1, 0); tick();
      drive(1, 0, 6, 0, 1, 0, 0, 0, 0); tick();
      drive(1, 0, 6, 0, 1, 0, 0, 0, 0); tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sat_stall_b", 32'(stall_b), 32'd15);
    check("sat_stall_a", 32'(stall_a), 32'd21);
    tick();

    // Async reset in the middle of a stall.
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0); tick();
    drive(1, 6, 0, 1, 0, 0, 0, 0, 0);
    check("mid_ready_pre", 32'(ready_a), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_ready_a", 32'(ready_a), 32'd1);
    check("mid_ready_b", 32'(ready_b), 32'd1);
    check("mid_stall_b", 32'(stall_b), 32'd0);
    check("mid_flush_a", 32'(flush_a), 32'd0);
    check("mid_fwd_rs", 32'(fwd_rs_a), 32'd0);
    m_reset();
    @(negedge clock);
    reset_n = 1'b1;

    // Random traffic; a stalled instruction is held by the upstream.
    begin
      bit v, urs, urt, wr, ld, fl, held;
      int rs, rt, rd;
      held = 0;
      v = 0; urs = 0; urt = 0; wr = 0; ld = 0; rs = 0; rt = 0; rd = 0;
      for (int i = 0; i < 500; i++) begin
        if (!held) begin
          v   = ($urandom_range(0, 9) < 8);
          rs  = $urandom_range(0, 7);
          rt  = $urandom_range(0, 7);
          urs = $urandom_range(0, 1);
          urt = $urandom_range(0, 1);
          wr  = ($urandom_range(0, 9) < 7);
          rd  = $urandom_range(0, 7);
          ld  = ($urandom_range(0, 9) < 4);
        end
        fl = ($urandom_range(0, 9) == 0);
        drive(v, rs, rt, urs, urt, wr, rd, ld, fl);
        held = v && !m_rdy;
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
